// File: rtl/interrupt_controller.sv
// Interrupt controller: IF/IE/IME registers with delayed EI, fixed-priority arbitration
// (bit 0 highest) and the request/acknowledge/vector handshake with the control unit.
module interrupt_controller #(
  parameter int unsigned N_IRQ         = 5,
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter int unsigned VECTOR_STRIDE = 8
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Enable,
  input  logic [N_IRQ-1:0] i_Irq,
  input  logic             i_Reg_Sel,
  input  logic             i_Reg_Write,
  input  logic [7:0]       i_Reg_Data,
  output logic [7:0]       o_Reg_Data,
  input  logic             i_Instr_Boundary,
  input  logic             i_Ei,
  input  logic             i_Di,
  input  logic             i_Reti,
  input  logic             i_Ack,
  output logic             o_Irq_Req,
  output logic [15:0]      o_Vector,
  output logic             o_Vector_Valid,
  output logic             o_Wake
);

  typedef enum logic [1:0] {IDLE, REQ, DISPATCH} state_t;

  state_t           state_q, state_d;
  logic [N_IRQ-1:0] flag_q, enable_q, irq_prev_q;
  logic             ime_q, ei_pend_q;
  logic [15:0]      vec_q;

  logic [N_IRQ-1:0] pending, edges, flag_wr, enable_wr, pend_ack, clr_mask, ack_clr;
  logic [15:0]      vec_d;
  logic             take_ack, found, ime_d, ei_pend_d;
  logic             reg_data_unused;

  assign reg_data_unused = ^i_Reg_Data;

  assign pending   = flag_q & enable_q;
  assign edges     = i_Irq & ~irq_prev_q;
  assign take_ack  = (state_q == REQ) && i_Ack;
  assign flag_wr   = (i_Reg_Write && !i_Reg_Sel) ? i_Reg_Data[N_IRQ-1:0] : flag_q;
  assign enable_wr = (i_Reg_Write &&  i_Reg_Sel) ? i_Reg_Data[N_IRQ-1:0] : enable_q;
  // Arbitration sees register writes landing in the ack cycle, so a write that
  // empties pending turns the dispatch into a cancelled one.
  assign pend_ack  = flag_wr & enable_wr;
  assign ack_clr   = take_ack ? clr_mask : '0;

  always_comb begin
    found    = 1'b0;
    clr_mask = '0;
    vec_d    = '0;
    for (int unsigned n = 0; n < N_IRQ; n++) begin
      if (pend_ack[n] && !found) begin
        found       = 1'b1;
        clr_mask[n] = 1'b1;
        vec_d       = VECTOR_BASE + 16'(n * VECTOR_STRIDE);
      end
    end
  end

  always_comb begin
    ime_d     = ime_q;
    ei_pend_d = ei_pend_q;
    if (ei_pend_q && i_Instr_Boundary) begin
      ime_d     = 1'b1;
      ei_pend_d = 1'b0;
    end
    if (i_Ei)     ei_pend_d = 1'b1;
    if (i_Reti)   ime_d     = 1'b1;
    if (take_ack) ime_d     = 1'b0;
    if (i_Di) begin
      ime_d     = 1'b0;
      ei_pend_d = 1'b0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      flag_q     <= '0;
      enable_q   <= '0;
      ime_q      <= 1'b0;
      ei_pend_q  <= 1'b0;
      irq_prev_q <= i_Irq;
      vec_q      <= '0;
    end else if (i_Enable) begin
      // Edge sets are ORed last so they survive both a write and an ack clear.
      flag_q     <= (flag_wr & ~ack_clr) | edges;
      enable_q   <= enable_wr;
      ime_q      <= ime_d;
      ei_pend_q  <= ei_pend_d;
      irq_prev_q <= i_Irq;
      if (take_ack) vec_q <= vec_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset)       state_q <= IDLE;
    else if (i_Enable) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (ime_q && |pending && i_Instr_Boundary) state_d = REQ;
      REQ:      if (i_Ack) state_d = DISPATCH;
                else if (!(|pending)) state_d = IDLE;
      DISPATCH: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    o_Irq_Req      = (state_q == REQ);
    o_Vector_Valid = (state_q == DISPATCH);
    o_Vector       = (state_q == DISPATCH) ? vec_q : '0;
    o_Wake         = |pending;
    o_Reg_Data     = '1;
    o_Reg_Data[N_IRQ-1:0] = i_Reg_Sel ? enable_q : flag_q;
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios followed by random traffic, checked
// against a behavioural model; dispatch vectors go through a scoreboard queue.
module tb_interrupt_controller;
  localparam int unsigned N = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, sel, wr, boundary, ei, di, reti, ack;
  logic [N-1:0] irq;
  logic [7:0]   wdata, rdata;
  logic         req, vvalid, wake;
  logic [15:0]  vec;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  logic [N-1:0] m_if, m_ie, m_prev;
  bit m_ime = 0, m_arm = 0, m_req = 0, m_disp = 0;

  interrupt_controller #(.N_IRQ(N), .VECTOR_BASE(16'h0040), .VECTOR_STRIDE(8)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_Enable(en), .i_Irq(irq),
    .i_Reg_Sel(sel), .i_Reg_Write(wr), .i_Reg_Data(wdata), .o_Reg_Data(rdata),
    .i_Instr_Boundary(boundary), .i_Ei(ei), .i_Di(di), .i_Reti(reti), .i_Ack(ack),
    .o_Irq_Req(req), .o_Vector(vec), .o_Vector_Valid(vvalid), .o_Wake(wake)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_read();
    logic [7:0] r;
    r = 8'hFF;
    r[N-1:0] = sel ? m_ie : m_if;
    return r;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_tick();
    logic [N-1:0] rise, nif, nie, p;
    bit accept;
    int idx;
    if (rst) begin
      m_if = '0; m_ie = '0; m_ime = 0; m_arm = 0; m_req = 0; m_disp = 0; m_prev = irq;
    end else if (en) begin
      rise   = irq & ~m_prev;
      nif    = (wr && !sel) ? wdata[N-1:0] : m_if;
      nie    = (wr &&  sel) ? wdata[N-1:0] : m_ie;
      accept = m_req && ack;
      if (accept) begin
        p = nif & nie;
        if (p == '0) exp_q.push_back(16'h0000);
        else begin
          idx = 0;
          while (!p[idx]) idx++;
          exp_q.push_back(16'(32'h0040 + idx * 8));
          nif[idx] = 1'b0;
        end
      end
      if (m_disp)      m_disp = 0;
      else if (m_req) begin
        if (accept) begin m_req = 0; m_disp = 1; end
        else if ((m_if & m_ie) == '0) m_req = 0;
      end else if (m_ime && (m_if & m_ie) != '0 && boundary) m_req = 1;
      m_ime  = di ? 1'b0 : accept ? 1'b0 : (reti || (m_arm && boundary)) ? 1'b1 : m_ime;
      m_arm  = di ? 1'b0 : ei ? 1'b1 : (m_arm && boundary) ? 1'b0 : m_arm;
      m_if   = nif | rise;
      m_ie   = nie;
      m_prev = irq;
    end
  endtask

  task automatic step();
    if (m_disp) en = 1'b1;
    model_tick();
    @(negedge clk);
    check("irq_req", req, m_req);
    check("vector_valid", vvalid, m_disp);
    check("wake", wake, |(m_if & m_ie));
    check("reg_data", rdata, model_read());
  endtask

  task automatic clr();
    rst = 0; en = 1; sel = 0; wr = 0; wdata = '0;
    boundary = 0; ei = 0; di = 0; reti = 0; ack = 0;
  endtask

  always @(negedge clk) begin
    if (vvalid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL vector_unexpected: got %0h expected no pulse", vec);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (vec !== e) begin
          errors++;
          $display("FAIL vector: got %0h expected %0h", vec, e);
        end
      end
    end
  end

  initial begin
    clr(); rst = 1; irq = '0;
    @(negedge clk);
    step(); step();
    check("reset_if_read", rdata, 8'hE0);
    check("reset_vector", vec, 16'h0000);

    clr(); sel = 1; wr = 1; wdata = 8'h1F; step();
    clr(); reti = 1; step();
    clr(); irq = 5'b00100; step();
    clr(); irq = '0; boundary = 1; step();
    check("t1_req", req, 1'b1);
    clr(); ack = 1; step();
    check("t1_vector", vec, 16'h0050);
    clr(); step();
    check("t1_if_cleared", rdata, 8'hE0);
    clr(); boundary = 1; step();
    check("t1_ime_cleared", req, 1'b0);

    clr(); wr = 1; wdata = 8'h16; step();
    clr(); reti = 1; step();
    clr(); boundary = 1; step();
    check("t2_req", req, 1'b1);
    clr(); ack = 1; step();
    check("t2_vector", vec, 16'h0048);
    clr(); step();
    check("t2_if_after", rdata, 8'hF4);

    clr(); ei = 1; step();
    clr(); boundary = 1; step();
    check("t3_no_req_first_boundary", req, 1'b0);
    clr(); boundary = 1; step();
    check("t3_req_next_boundary", req, 1'b1);
    clr(); ack = 1; step();
    check("t3_vector", vec, 16'h0050);
    clr(); step();

    clr(); reti = 1; step();
    clr(); boundary = 1; step();
    check("t4_req", req, 1'b1);
    clr(); ack = 1; wr = 1; sel = 1; wdata = 8'h00; step();
    check("t4_cancel_vector", vec, 16'h0000);
    check("t4_cancel_valid", vvalid, 1'b1);
    clr(); step();
    check("t4_if_unchanged", rdata, 8'hF0);
    clr(); wr = 1; sel = 1; wdata = 8'h1F; step();
    clr(); boundary = 1; step();
    check("t4_ime_cleared", req, 1'b0);

    check("t5_wake", wake, 1'b1);
    clr(); ei = 1; di = 1; step();
    clr(); boundary = 1; step();
    clr(); boundary = 1; step();
    check("t5_ime_stays_0", req, 1'b0);

    clr(); wr = 1; wdata = 8'h00; step();
    clr(); wr = 1; sel = 1; wdata = 8'h01; step();
    clr(); irq = 5'b00001; step();
    clr(); reti = 1; step();
    clr(); boundary = 1; step();
    check("t6_req", req, 1'b1);
    clr(); ack = 1; step();
    check("t6_vector", vec, 16'h0040);
    clr(); step(); step();
    check("t6_held_level_no_set", rdata, 8'hE0);
    clr(); wr = 1; wdata = 8'h01; irq = 5'b01001; step();
    check("t6_write_plus_edge", rdata, 8'hE9);
    clr(); irq = '0; step();

    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] flip;
      clr();
      flip = '0;
      for (int b = 0; b < N; b++) flip[b] = ($urandom_range(7) == 0);
      irq      = irq ^ flip;
      rst      = ($urandom_range(149) == 0);
      en       = ($urandom_range(7) != 0);
      sel      = $urandom_range(1);
      wr       = ($urandom_range(7) == 0);
      wdata    = 8'($urandom);
      boundary = $urandom_range(1);
      ei       = ($urandom_range(11) == 0);
      di       = ($urandom_range(19) == 0);
      reti     = ($urandom_range(11) == 0);
      ack      = ($urandom_range(2) == 0);
      step();
    end

    clr(); step(); step(); step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
